// File: rtl/e2_out_monitor_if.sv
// Bundle between the e2 controller output monitor and its harness.
// master: harness side (drives y/start/ack, reads results).
// slave : monitor side (reads y/start/ack, drives busy/done/sig/illegal_cnt/class_out/rep_alarm).
interface e2_out_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic [17:0]      y;
    logic             start;
    logic             ack;
    logic             busy;
    logic             done;
    logic [15:0]      sig;
    logic [CNT_W-1:0] illegal_cnt;
    logic [4:0]       class_out;
    logic             rep_alarm;

    modport master (
        output y, start, ack,
        input  busy, done, sig, illegal_cnt, class_out, rep_alarm
    );

    modport slave (
        input  y, start, ack,
        output busy, done, sig, illegal_cnt, class_out, rep_alarm
    );
endinterface

// File: rtl/e2_out_monitor.sv
// e2_out_monitor: samples the e2 controller's 18-bit output word over a
// capture window, classifies each word, compacts samples into a 16-bit MISR,
// counts illegal words and flags long runs of one repeated nonzero class.
// Ports:
//   clk  - rising-edge sampling clock
//   rst  - asynchronous, active-high reset
//   bus  - e2_out_monitor_if.slave: y/start/ack in; busy/done/sig/
//          illegal_cnt/class_out/rep_alarm out (all registered)
module e2_out_monitor #(
    parameter int unsigned WIN_LEN = 64,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned REP_LIM = 4
) (
    input logic            clk,
    input logic            rst,
    e2_out_monitor_if.slave bus
);
    localparam int unsigned SC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned RC_W = $clog2(REP_LIM + 1);
    localparam logic [4:0]  CLS_ILLEGAL = 5'd31;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    // Exact-match classification against the controller's legal output set.
    function automatic logic [4:0] classify(input logic [17:0] w);
        case (w)
            18'h00000: return 5'd0;
            18'h00001: return 5'd1;   // y1
            18'h00002: return 5'd2;   // y2
            18'h00004: return 5'd3;   // y3
            18'h00008: return 5'd4;   // y4
            18'h00010: return 5'd5;   // y5
            18'h00020: return 5'd6;   // y6
            18'h00200: return 5'd7;   // y10
            18'h01000: return 5'd8;   // y13
            18'h02000: return 5'd9;   // y14
            18'h04000: return 5'd10;  // y15
            18'h08000: return 5'd11;  // y16
            18'h20800: return 5'd12;  // y12,y18
            18'h10080: return 5'd13;  // y8,y17
            18'h000C0: return 5'd14;  // y7,y8
            18'h00C01: return 5'd15;  // y1,y11,y12
            18'h00D00: return 5'd16;  // y9,y11,y12
            default:   return CLS_ILLEGAL;
        endcase
    endfunction

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      sig_q;
    logic [CNT_W-1:0] ill_q;
    logic [4:0]       class_q;
    logic             alarm_q;
    logic [SC_W-1:0]  samp_q;
    logic [RC_W-1:0]  run_q;

    logic [4:0]       cls_c;
    logic [15:0]      d_c;
    logic [15:0]      sig_nxt_c;
    logic [RC_W-1:0]  run_nxt_c;

    // Per-sample combinational terms: class, MISR next value, next run length.
    // class_q holds the previous edge's class, which is the previous sample's
    // class everywhere in RUN except the first sample of the window.
    always_comb begin
        cls_c     = classify(bus.y);
        d_c       = bus.y[15:0] ^ {14'b0, bus.y[17:16]};
        sig_nxt_c = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ d_c;
        run_nxt_c = '0;
        if (cls_c != 5'd0) begin
            if (samp_q != '0 && cls_c == class_q) begin
                run_nxt_c = (run_q == RC_W'(REP_LIM)) ? run_q : run_q + RC_W'(1);
            end else begin
                run_nxt_c = RC_W'(1);
            end
        end
    end

    // Window control FSM and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= '0;
            ill_q   <= '0;
            class_q <= '0;
            alarm_q <= 1'b0;
            samp_q  <= '0;
            run_q   <= '0;
        end else begin
            class_q <= cls_c;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        sig_q   <= '0;
                        ill_q   <= '0;
                        alarm_q <= 1'b0;
                        samp_q  <= '0;
                        run_q   <= '0;
                    end
                end
                RUN: begin
                    sig_q <= sig_nxt_c;
                    run_q <= run_nxt_c;
                    if (cls_c == CLS_ILLEGAL && ill_q != {CNT_W{1'b1}}) begin
                        ill_q <= ill_q + CNT_W'(1);
                    end
                    if (run_nxt_c == RC_W'(REP_LIM)) begin
                        alarm_q <= 1'b1;
                    end
                    if (samp_q == SC_W'(WIN_LEN - 1)) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        samp_q  <= '0;
                    end else begin
                        samp_q <= samp_q + SC_W'(1);
                    end
                end
                HOLD: begin
                    // ack takes priority; start is never looked at here
                    if (bus.ack) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.sig         = sig_q;
    assign bus.illegal_cnt = ill_q;
    assign bus.class_out   = class_q;
    assign bus.rep_alarm   = alarm_q;
endmodule

// File: tb/tb_e2_out_monitor.sv
// Testbench for e2_out_monitor: directed windows from the test plan plus
// randomized windows, checked against a window-level reference model.
module tb_e2_out_monitor;
    localparam int unsigned WIN_LEN = 6;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned REP_LIM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    e2_out_monitor_if #(.CNT_W(CNT_W)) bus ();

    e2_out_monitor #(
        .WIN_LEN(WIN_LEN),
        .CNT_W  (CNT_W),
        .REP_LIM(REP_LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Legal word for each class index 0..16.
    logic [17:0] legal [17] = '{
        18'h00000, 18'h00001, 18'h00002, 18'h00004, 18'h00008, 18'h00010,
        18'h00020, 18'h00200, 18'h01000, 18'h02000, 18'h04000, 18'h08000,
        18'h20800, 18'h10080, 18'h000C0, 18'h00C01, 18'h00D00
    };

    logic [17:0] ys [WIN_LEN];

    // Reference model state for the current window.
    logic [15:0] m_sig;
    int          m_ill;
    int          m_run;
    int          m_prev;
    int          m_cls;
    logic        m_alarm;

    function automatic int ref_class(input logic [17:0] w);
        for (int i = 0; i < 17; i++) begin
            if (w == legal[i]) return i;
        end
        return 31;
    endfunction

    // MISR as polynomial arithmetic: multiply by x mod (x^16+x^12+x^5+1), add folded word.
    function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [17:0] w);
        logic [16:0] p;
        p = {s, 1'b0};
        if (p[16]) p = p ^ 17'h11021;
        return p[15:0] ^ w[15:0] ^ 16'(w[17:16]);
    endfunction

    function automatic int sat_ill(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sig = 16'h0; m_ill = 0; m_run = 0; m_prev = -1; m_alarm = 1'b0;
    endtask

    task automatic model_sample(input logic [17:0] w);
        int c;
        c = ref_class(w);
        m_sig = ref_misr(m_sig, w);
        if (c == 31) m_ill++;
        if (c != 0 && c == m_prev) m_run++;
        else m_run = (c != 0) ? 1 : 0;
        if (m_run >= int'(REP_LIM)) m_alarm = 1'b1;
        m_prev = c;
        m_cls  = c;
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_sig"},   32'(bus.sig),         32'(m_sig));
        chk({tag, "_ill"},   32'(bus.illegal_cnt), 32'(sat_ill(m_ill)));
        chk({tag, "_alarm"}, 32'(bus.rep_alarm),   32'(m_alarm));
    endtask

    // One full window using ys[]; start is re-asserted mid-window to show it is ignored.
    task automatic run_window(input string tag);
        @(negedge clk);
        bus.start = 1'b1; bus.ack = 1'b0; bus.y = 18'($urandom);
        @(posedge clk);
        model_reset();
        for (int k = 0; k < int'(WIN_LEN); k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_done"}, 32'(bus.done), 32'd0);
            chk_results({tag, "_mid"});
            if (k > 0) chk({tag, "_cls"}, 32'(bus.class_out), 32'(m_cls));
            bus.start = (k == 1);
            bus.y     = ys[k];
            @(posedge clk);
            model_sample(ys[k]);
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_done_end"}, 32'(bus.done),      32'd1);
        chk({tag, "_busy_end"}, 32'(bus.busy),      32'd0);
        chk({tag, "_cls_end"},  32'(bus.class_out), 32'(m_cls));
        chk_results({tag, "_end"});
    endtask

    task automatic release_hold();
        @(negedge clk);
        bus.ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1; bus.start = 1'b0; bus.ack = 1'b0; bus.y = 18'h0;
        #12;
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_done",  32'(bus.done),        32'd0);
        chk("rst_sig",   32'(bus.sig),         32'd0);
        chk("rst_ill",   32'(bus.illegal_cnt), 32'd0);
        chk("rst_cls",   32'(bus.class_out),   32'd0);
        chk("rst_alarm", 32'(bus.rep_alarm),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All-zero window.
        for (int k = 0; k < int'(WIN_LEN); k++) ys[k] = 18'h0;
        run_window("zero");
        chk("zero_sig_const", 32'(bus.sig), 32'h0000);
        release_hold();

        // y1 held: shift-and-or signature, run alarm.
        for (int k = 0; k < int'(WIN_LEN); k++) ys[k] = 18'h00001;
        run_window("y1");
        chk("y1_sig_const",   32'(bus.sig),       32'h003F);
        chk("y1_cls_const",   32'(bus.class_out), 32'd1);
        chk("y1_alarm_const", 32'(bus.rep_alarm), 32'd1);
        release_hold();

        // Class 12 / illegal / class 12 / zeros.
        ys[0] = 18'h20800; ys[1] = 18'h3FFFF; ys[2] = 18'h20800;
        ys[3] = 18'h0;     ys[4] = 18'h0;     ys[5] = 18'h0;
        run_window("mix");
        chk("mix_ill_const",   32'(bus.illegal_cnt), 32'd1);
        chk("mix_alarm_const", 32'(bus.rep_alarm),   32'd0);
        release_hold();

        // All-ones: counter saturates, illegal class still raises the run alarm.
        for (int k = 0; k < int'(WIN_LEN); k++) ys[k] = 18'h3FFFF;
        run_window("ones");
        chk("ones_ill_const",   32'(bus.illegal_cnt), 32'd3);
        chk("ones_alarm_const", 32'(bus.rep_alarm),   32'd1);

        // HOLD: results frozen for 10 cycles, start alone ignored.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = (i % 3 == 0);
            bus.ack   = 1'b0;
            bus.y     = legal[$urandom_range(0, 16)];
            m_cls     = ref_class(bus.y);
            @(posedge clk);
            @(negedge clk);
            chk("hold_done", 32'(bus.done),      32'd1);
            chk("hold_busy", 32'(bus.busy),      32'd0);
            chk("hold_cls",  32'(bus.class_out), 32'(m_cls));
            chk_results("hold");
        end
        // start together with ack: ack wins, results stay readable in IDLE.
        @(negedge clk);
        bus.start = 1'b1; bus.ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.ack = 1'b0;
        chk("ackstart_done", 32'(bus.done), 32'd0);
        chk("ackstart_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk_results("idle");

        // Next start clears the results.
        for (int k = 0; k < int'(WIN_LEN); k++) ys[k] = legal[k + 1];
        run_window("after");
        release_hold();

        // Asynchronous reset after the 2nd sample of a RUN.
        @(negedge clk);
        bus.start = 1'b1; bus.y = 18'h0;
        @(posedge clk);
        model_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.y = 18'h00005;
            @(posedge clk);
            model_sample(18'h00005);
        end
        #2;
        chk("pre_rst_sig", 32'(bus.sig), 32'(m_sig));
        rst = 1'b1;
        #1;
        chk("arst_busy",  32'(bus.busy),        32'd0);
        chk("arst_sig",   32'(bus.sig),         32'd0);
        chk("arst_ill",   32'(bus.illegal_cnt), 32'd0);
        chk("arst_cls",   32'(bus.class_out),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_done", 32'(bus.done), 32'd0);
        for (int k = 0; k < int'(WIN_LEN); k++) ys[k] = 18'h00005;
        run_window("clean");
        release_hold();

        // Randomized windows biased toward repeats and legal words.
        for (int w = 0; w < 12; w++) begin
            for (int k = 0; k < int'(WIN_LEN); k++) begin
                r = int'($urandom_range(0, 4));
                case (r)
                    0, 1:    ys[k] = (k > 0) ? ys[k-1] : legal[$urandom_range(1, 16)];
                    2:       ys[k] = legal[$urandom_range(0, 16)];
                    3:       ys[k] = 18'($urandom);
                    default: ys[k] = legal[$urandom_range(1, 3)];
                endcase
            end
            run_window("rand");
            release_hold();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
